// File: rtl/mor1kx_rf_operand_read_espresso_if.sv
// Writeback and operand-read signal bundle for the espresso GPR file.
// The master drives the writeback and read requests; the slave returns registered operands.
interface mor1kx_rf_operand_read_espresso_if #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5
);
  logic                            rf_wb_i;
  logic [OPTION_RF_ADDR_WIDTH-1:0] rfd_adr_i;
  logic [OPTION_OPERAND_WIDTH-1:0] rf_result_i;
  logic                            rf_re_i;
  logic [OPTION_RF_ADDR_WIDTH-1:0] rfa_adr_i;
  logic [OPTION_RF_ADDR_WIDTH-1:0] rfb_adr_i;
  logic [OPTION_OPERAND_WIDTH-1:0] rfa_o;
  logic [OPTION_OPERAND_WIDTH-1:0] rfb_o;
  logic                            rf_valid_o;

  modport master (
    output rf_wb_i, rfd_adr_i, rf_result_i, rf_re_i, rfa_adr_i, rfb_adr_i,
    input  rfa_o, rfb_o, rf_valid_o
  );

  modport slave (
    input  rf_wb_i, rfd_adr_i, rf_result_i, rf_re_i, rfa_adr_i, rfb_adr_i,
    output rfa_o, rfb_o, rf_valid_o
  );
endinterface

// File: rtl/mor1kx_rf_operand_read_espresso.sv
// Espresso GPR file: stores writeback results and returns registered A/B operands,
// with same-cycle write bypass and refresh of operands held across stalls.
module mor1kx_rf_operand_read_espresso #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5
) (
  input logic clk,
  input logic rst,
  mor1kx_rf_operand_read_espresso_if.slave bus
);
  localparam int RF_ENTRIES = 2 ** OPTION_RF_ADDR_WIDTH;

  logic [OPTION_OPERAND_WIDTH-1:0] mem [RF_ENTRIES];
  logic [OPTION_RF_ADDR_WIDTH-1:0] ha_reg;
  logic [OPTION_RF_ADDR_WIDTH-1:0] hb_reg;
  logic [OPTION_OPERAND_WIDTH-1:0] rfa_reg;
  logic [OPTION_OPERAND_WIDTH-1:0] rfb_reg;
  logic                            valid_reg;

  logic wr_en;
  logic byp_a;
  logic byp_b;
  logic refresh_a;
  logic refresh_b;

  assign wr_en = bus.rf_wb_i && (bus.rfd_adr_i != '0);

  // Bypass compares against the live read address; refresh against the held one.
  assign byp_a     = wr_en && (bus.rfd_adr_i == bus.rfa_adr_i);
  assign byp_b     = wr_en && (bus.rfd_adr_i == bus.rfb_adr_i);
  assign refresh_a = wr_en && valid_reg && (bus.rfd_adr_i == ha_reg);
  assign refresh_b = wr_en && valid_reg && (bus.rfd_adr_i == hb_reg);

  // Storage has no reset so it maps onto RAM; a write at an edge where rst is high is dropped.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[bus.rfd_adr_i] <= bus.rf_result_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rfa_reg   <= '0;
      rfb_reg   <= '0;
      ha_reg    <= '0;
      hb_reg    <= '0;
      valid_reg <= 1'b0;
    end else if (bus.rf_re_i) begin
      ha_reg    <= bus.rfa_adr_i;
      hb_reg    <= bus.rfb_adr_i;
      valid_reg <= 1'b1;
      if (bus.rfa_adr_i == '0) begin
        rfa_reg <= '0;
      end else if (byp_a) begin
        rfa_reg <= bus.rf_result_i;
      end else begin
        rfa_reg <= mem[bus.rfa_adr_i];
      end
      if (bus.rfb_adr_i == '0) begin
        rfb_reg <= '0;
      end else if (byp_b) begin
        rfb_reg <= bus.rf_result_i;
      end else begin
        rfb_reg <= mem[bus.rfb_adr_i];
      end
    end else begin
      if (refresh_a) begin
        rfa_reg <= bus.rf_result_i;
      end
      if (refresh_b) begin
        rfb_reg <= bus.rf_result_i;
      end
    end
  end

  assign bus.rfa_o      = rfa_reg;
  assign bus.rfb_o      = rfb_reg;
  assign bus.rf_valid_o = valid_reg;
endmodule

// File: tb/tb_mor1kx_rf_operand_read_espresso.sv
// Directed bench for the espresso GPR operand-read block.
module tb_mor1kx_rf_operand_read_espresso;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mor1kx_rf_operand_read_espresso_if #(
    .OPTION_OPERAND_WIDTH(32),
    .OPTION_RF_ADDR_WIDTH(5)
  ) bus ();

  mor1kx_rf_operand_read_espresso #(
    .OPTION_OPERAND_WIDTH(32),
    .OPTION_RF_ADDR_WIDTH(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive(input logic wb, input logic [4:0] d, input logic [31:0] data,
                       input logic re, input logic [4:0] a, input logic [4:0] b);
    bus.rf_wb_i     = wb;
    bus.rfd_adr_i   = d;
    bus.rf_result_i = data;
    bus.rf_re_i     = re;
    bus.rfa_adr_i   = a;
    bus.rfb_adr_i   = b;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    cyc();
    cyc();
    check("rst_a", bus.rfa_o, 32'h0);
    check("rst_b", bus.rfb_o, 32'h0);
    check("rst_valid", {31'b0, bus.rf_valid_o}, 32'h0);
    rst = 1'b0;

    // 1: write-then-read
    drive(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
    cyc();
    check("wr_novalid", {31'b0, bus.rf_valid_o}, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0);
    cyc();
    check("t1_a", bus.rfa_o, 32'hDEADBEEF);
    check("t1_b", bus.rfb_o, 32'h0);
    check("t1_valid", {31'b0, bus.rf_valid_o}, 32'h1);

    // 2: same-cycle bypass
    drive(1'b1, 5'd5, 32'h11111111, 1'b0, 5'd0, 5'd0);
    cyc();
    drive(1'b1, 5'd5, 32'h22222222, 1'b1, 5'd5, 5'd5);
    cyc();
    check("byp_a", bus.rfa_o, 32'h22222222);
    check("byp_b", bus.rfb_o, 32'h22222222);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd3);
    cyc();
    check("byp_reread_a", bus.rfa_o, 32'h22222222);
    check("byp_reread_b", bus.rfb_o, 32'hDEADBEEF);

    // 3: r0 protection
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0);
    cyc();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
    cyc();
    check("r0_a", bus.rfa_o, 32'h0);
    check("r0_b", bus.rfb_o, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd3);
    cyc();
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0);
    cyc();
    check("r0_byp_a", bus.rfa_o, 32'h0);
    check("r0_byp_b", bus.rfb_o, 32'h0);

    // 4: stalled refresh
    drive(1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 5'd0);
    cyc();
    drive(1'b1, 5'd8, 32'h2, 1'b0, 5'd0, 5'd0);
    cyc();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd8);
    cyc();
    check("stall_rd_a", bus.rfa_o, 32'h1);
    check("stall_rd_b", bus.rfb_o, 32'h2);
    drive(1'b1, 5'd8, 32'h99, 1'b0, 5'd7, 5'd8);
    cyc();
    check("refresh_b_a", bus.rfa_o, 32'h1);
    check("refresh_b_b", bus.rfb_o, 32'h99);
    drive(1'b1, 5'd9, 32'h55, 1'b0, 5'd7, 5'd8);
    cyc();
    check("other_wr_a", bus.rfa_o, 32'h1);
    check("other_wr_b", bus.rfb_o, 32'h99);
    drive(1'b1, 5'd7, 32'h77, 1'b0, 5'd7, 5'd8);
    cyc();
    check("refresh_a_a", bus.rfa_o, 32'h77);
    check("refresh_a_b", bus.rfb_o, 32'h99);
    // live addresses move away; refresh must follow the held indices
    drive(1'b1, 5'd8, 32'hAA, 1'b0, 5'd3, 5'd3);
    cyc();
    check("held_idx_a", bus.rfa_o, 32'h77);
    check("held_idx_b", bus.rfb_o, 32'hAA);

    // 5: asynchronous reset with a coincident write
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd3);
    cyc();
    check("pre_rst_a", bus.rfa_o, 32'h22222222);
    check("pre_rst_b", bus.rfb_o, 32'hDEADBEEF);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd3);
    #2;
    rst = 1'b1;
    drive(1'b1, 5'd5, 32'hBAD0BAD0, 1'b0, 5'd5, 5'd3);
    #1;
    check("arst_a", bus.rfa_o, 32'h0);
    check("arst_b", bus.rfb_o, 32'h0);
    check("arst_valid", {31'b0, bus.rf_valid_o}, 32'h0);
    cyc();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    cyc();
    check("post_rst_valid", {31'b0, bus.rf_valid_o}, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd0);
    cyc();
    check("lost_wr_a", bus.rfa_o, 32'h22222222);
    check("post_rd_valid", {31'b0, bus.rf_valid_o}, 32'h1);

    // 6: back-to-back reads with r2 written in the first read cycle
    drive(1'b1, 5'd1, 32'h101, 1'b0, 5'd0, 5'd0);
    cyc();
    drive(1'b1, 5'd2, 32'h202, 1'b0, 5'd0, 5'd0);
    cyc();
    drive(1'b1, 5'd2, 32'h2222, 1'b1, 5'd1, 5'd1);
    cyc();
    check("b2b_r1_a", bus.rfa_o, 32'h101);
    check("b2b_r1_b", bus.rfb_o, 32'h101);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 5'd2);
    cyc();
    check("b2b_r2_a", bus.rfa_o, 32'h2222);
    check("b2b_r2_b", bus.rfb_o, 32'h2222);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3);
    cyc();
    check("b2b_r3_a", bus.rfa_o, 32'hDEADBEEF);
    check("b2b_r3_b", bus.rfb_o, 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mor1kx_rf_operand_read_espresso.md
Name: mor1kx_rf_operand_read_espresso

Overview:
- Consumer side of the espresso writeback path: accepts the RF writeback result, stores it in a 32-entry GPR file, and returns registered A/B operands to decode/execute.
- Resolves same-cycle write/read hazards internally so execute never sees stale operands.
- Keeps held operands coherent while the pipeline is stalled.
- Sits between the writeback mux output and the ALU/LSU operand inputs.

Parameters:
- OPTION_OPERAND_WIDTH, 32, GPR data width.
- OPTION_RF_ADDR_WIDTH, 5, GPR index width; the file has 2**OPTION_RF_ADDR_WIDTH entries.

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous active-high reset.
- rf_wb_i  input  1  writeback enable this cycle.
- rfd_adr_i  input  OPTION_RF_ADDR_WIDTH  writeback destination index.
- rf_result_i  input  OPTION_OPERAND_WIDTH  writeback data from the RF result mux.
- rf_re_i  input  1  operand read request; a new instruction is in decode.
- rfa_adr_i  input  OPTION_RF_ADDR_WIDTH  operand A index.
- rfb_adr_i  input  OPTION_RF_ADDR_WIDTH  operand B index.
- rfa_o  output  OPTION_OPERAND_WIDTH  registered operand A.
- rfb_o  output  OPTION_OPERAND_WIDTH  registered operand B.
- rf_valid_o  output  1  operands on rfa_o/rfb_o correspond to the most recent accepted read.

Behaviour:
- Reset (async, rst=1):
  - rfa_o=0, rfb_o=0, rf_valid_o=0.
  - Held-address registers are cleared to 0.
  - GPR storage is not reset; entries other than r0 are undefined until written.
- Write:
  - On a rising edge with rf_wb_i=1 and rfd_adr_i!=0, mem[rfd_adr_i] <= rf_result_i.
  - Writes to r0 are discarded. r0 always reads 0.
- Read latency: 1 cycle.
  - With rf_re_i=1 at edge N, rfa_o/rfb_o present the operands from edge N onward, and rf_valid_o=1 from edge N.
  - The block latches rfa_adr_i/rfb_adr_i into held-address registers ha/hb.
- Same-cycle bypass:
  - Condition: at the edge, rf_re_i=1, rf_wb_i=1, rfd_adr_i==rfa_adr_i, and rfd_adr_i!=0.
  - Then rfa_o <= rf_result_i, not the old mem content. Same rule for B.
  - If both A and B match, both receive rf_result_i.
- Read of r0: the output is 0 regardless of any bypass condition.
- Hold (rf_re_i=0):
  - Outputs, ha/hb and rf_valid_o keep their values.
  - Exception, held-operand refresh: if rf_wb_i=1, rfd_adr_i==ha, ha!=0 and rf_valid_o=1, then rfa_o <= rf_result_i. Same rule for B with hb.
  - This keeps stalled operands coherent with late writebacks.
- rf_valid_o:
  - Set by the first rf_re_i after reset.
  - Never cleared except by reset.
- Priority at one edge: reset > read (with bypass) > held refresh > hold.
- Reset mid-operation:
  - A write coincident with rst assertion is lost.
  - Outputs return to 0 immediately (asynchronously).
- No combinational path from any input to any output.

Test Plan:
1. Write-then-read:
   - Cycle 1: rf_wb_i=1, rfd_adr_i=3, rf_result_i=0xDEADBEEF.
   - Cycle 2: rf_re_i=1, rfa_adr_i=3, rfb_adr_i=0.
   - Expect rfa_o=0xDEADBEEF, rfb_o=0, rf_valid_o=1 after edge 2.
2. Same-cycle bypass:
   - mem[5]=0x11111111.
   - One cycle: rf_re_i=1, rfa_adr_i=rfb_adr_i=5, rf_wb_i=1, rfd_adr_i=5, rf_result_i=0x22222222.
   - Expect rfa_o=rfb_o=0x22222222; a later read of r5 returns 0x22222222.
3. r0 protection:
   - Write r0=0xFFFFFFFF, then read A=0,B=0.
   - Also bypass-write r0 in the same cycle as a read of r0.
   - Expect rfa_o=rfb_o=0 in both cases.
4. Stalled refresh:
   - Read A=7 (mem 0x1), B=8 (mem 0x2).
   - Then rf_re_i=0 and write r8=0x99.
   - Expect rfa_o=0x1, rfb_o=0x99 next edge.
   - A write to r9 during the stall leaves both outputs unchanged.
5. Reset:
   - Assert rst asynchronously mid-cycle after a valid read.
   - Expect rfa_o=rfb_o=0 and rf_valid_o=0 before the next edge.
   - With rf_wb_i=1 coincident with rst, the targeted entry is unchanged (verify by reading it after release).
6. Back-to-back reads:
   - Reads of r1,r2,r3 on consecutive cycles while r2 is written in the first of those cycles.
   - Expect each output sequence to track with 1-cycle latency, and the r2 read to return the new value.
